// File: rtl/frame_cpu_core.sv
// frame_cpu_core: 8-bit single-cycle core. Each rising edge executes one
// 17-bit frame against a 16x8 register file, a 32x8 SRAM and a 128x8 flash
// array. dout carries the pre-edge value of the addressed location. The LEDs
// show the inverted opcode that was latched from the frame.
module frame_cpu_core (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [16:0] frame,
    output logic [7:0]  dout,
    output logic [7:0]  pc,
    output logic        LED_B,
    output logic        LED_G,
    output logic        LED_R,
    output logic        LED
);

    logic [7:0] rf_q    [16];
    logic [7:0] sram_q  [32];
    logic [7:0] flash_q [128];
    logic [7:0] pc_q;
    logic [7:0] dout_q;
    logic [3:0] op_q;
    logic       z_q;

    logic [3:0] op;
    logic [3:0] fld_a;
    logic [3:0] fld_b;
    logic [3:0] fld_d;

    logic [7:0] alu_res;
    logic [7:0] pc_d;
    logic [7:0] dout_d;
    logic       z_d;
    logic       z_we;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       sram_we;
    logic [4:0] sram_waddr;
    logic [7:0] sram_wdata;
    logic       flash_we;
    logic [6:0] flash_waddr;
    logic [7:0] flash_wdata;

    // frame[0] is not used by any opcode
    logic unused_frame_bit;
    assign unused_frame_bit = frame[0];

    assign op    = frame[16:13];
    assign fld_a = frame[12:9];
    assign fld_b = frame[8:5];
    assign fld_d = frame[4:1];

    // Decode the frame into one write per storage array plus the next pc/dout/Z
    always_comb begin
        pc_d        = pc_q + 8'd1;
        dout_d      = 8'h00;
        z_d         = z_q;
        z_we        = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = fld_a;
        rf_wdata    = 8'h00;
        sram_we     = 1'b0;
        sram_waddr  = frame[12:8];
        sram_wdata  = rf_q[frame[7:4]];
        flash_we    = 1'b0;
        flash_waddr = frame[12:6];
        flash_wdata = rf_q[frame[5:2]];

        case (op)
            4'h3:    alu_res = rf_q[fld_a] + rf_q[fld_b];
            4'h4:    alu_res = rf_q[fld_a] - rf_q[fld_b];
            4'h5:    alu_res = rf_q[fld_a] & rf_q[fld_b];
            default: alu_res = rf_q[fld_a] | rf_q[fld_b];
        endcase

        case (op)
            4'h1: dout_d = rf_q[fld_a];
            4'h2: begin
                dout_d   = rf_q[fld_a];
                rf_we    = 1'b1;
                rf_wdata = {4'b0000, fld_b};
            end
            4'h3, 4'h4, 4'h5, 4'h6: begin
                dout_d   = rf_q[fld_d];
                rf_we    = 1'b1;
                rf_waddr = fld_d;
                rf_wdata = alu_res;
                z_we     = 1'b1;
                z_d      = (alu_res == 8'h00);
            end
            4'h7: begin
                dout_d   = rf_q[fld_a];
                rf_we    = 1'b1;
                rf_wdata = rf_q[fld_b];
            end
            4'h8: begin
                dout_d   = sram_q[frame[8:4]];
                rf_we    = 1'b1;
                rf_wdata = sram_q[frame[8:4]];
            end
            4'h9: begin
                dout_d  = sram_q[frame[12:8]];
                sram_we = 1'b1;
            end
            4'hA: begin
                dout_d   = flash_q[frame[8:2]];
                rf_we    = 1'b1;
                rf_wdata = flash_q[frame[8:2]];
            end
            4'hB: begin
                dout_d   = flash_q[frame[12:6]];
                flash_we = 1'b1;
            end
            4'hC: begin
                dout_d = pc_q;
                pc_d   = frame[12:5];
            end
            4'hD: begin
                dout_d = pc_q;
                if (!z_q) pc_d = frame[12:5];
            end
            4'hE: begin
                dout_d = pc_q;
                if (z_q) pc_d = frame[12:5];
            end
            default: dout_d = 8'h00;
        endcase
    end

    // State update; synchronous active-low reset clears every array and register
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++)  rf_q[i]    <= 8'h00;
            for (int i = 0; i < 32; i++)  sram_q[i]  <= 8'h00;
            for (int i = 0; i < 128; i++) flash_q[i] <= 8'h00;
            pc_q   <= 8'h00;
            dout_q <= 8'h00;
            op_q   <= 4'h0;
            z_q    <= 1'b0;
        end else begin
            op_q   <= op;
            pc_q   <= pc_d;
            dout_q <= dout_d;
            if (z_we)     z_q                  <= z_d;
            if (rf_we)    rf_q[rf_waddr]       <= rf_wdata;
            if (sram_we)  sram_q[sram_waddr]   <= sram_wdata;
            if (flash_we) flash_q[flash_waddr] <= flash_wdata;
        end
    end

    assign dout  = dout_q;
    assign pc    = pc_q;
    assign LED_B = ~op_q[0];
    assign LED_G = ~op_q[1];
    assign LED_R = ~op_q[2];
    assign LED   = ~op_q[3];

endmodule

// File: tb/tb_frame_cpu_core.sv
// Scoreboard bench for frame_cpu_core: the driver runs a behavioural model of
// the instruction set and queues the expected dout/pc/opcode; a monitor pops
// and compares one entry after each rising edge.
module tb_frame_cpu_core;

    logic        sysclk;
    logic        reset;
    logic [16:0] frame;
    logic [7:0]  dout;
    logic [7:0]  pc;
    logic        LED_B;
    logic        LED_G;
    logic        LED_R;
    logic        LED;

    frame_cpu_core dut (
        .sysclk (sysclk),
        .reset  (reset),
        .frame  (frame),
        .dout   (dout),
        .pc     (pc),
        .LED_B  (LED_B),
        .LED_G  (LED_G),
        .LED_R  (LED_R),
        .LED    (LED)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [7:0] dout;
        logic [7:0] pc;
        logic [3:0] op;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    // reference machine state
    logic [7:0] m_r [16];
    logic [7:0] m_m [32];
    logic [7:0] m_f [128];
    logic [7:0] m_pc;
    logic       m_z;

    function automatic logic [16:0] mkf(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] d);
        return {op, a, b, d, 1'b0};
    endfunction

    task automatic model_step(input logic r, input logic [16:0] f);
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic [7:0] nd;
        logic [7:0] npc;
        logic [7:0] res;
        exp_t       e;
        op  = f[16:13];
        a   = f[12:9];
        b   = f[8:5];
        d   = f[4:1];
        nd  = 8'h00;
        npc = m_pc + 8'd1;
        res = 8'h00;
        if (!r) begin
            for (int i = 0; i < 16; i++)  m_r[i] = 8'h00;
            for (int i = 0; i < 32; i++)  m_m[i] = 8'h00;
            for (int i = 0; i < 128; i++) m_f[i] = 8'h00;
            m_z  = 1'b0;
            m_pc = 8'h00;
            e.dout = 8'h00; e.pc = 8'h00; e.op = 4'h0;
        end else begin
            case (op)
                4'h1: nd = m_r[a];
                4'h2: begin nd = m_r[a]; m_r[a] = {4'h0, b}; end
                4'h3, 4'h4, 4'h5, 4'h6: begin
                    if (op == 4'h3)      res = 8'((int'(m_r[a]) + int'(m_r[b])) % 256);
                    else if (op == 4'h4) res = 8'((int'(m_r[a]) - int'(m_r[b]) + 256) % 256);
                    else if (op == 4'h5) res = m_r[a] & m_r[b];
                    else                 res = m_r[a] | m_r[b];
                    nd = m_r[d];
                    m_r[d] = res;
                    m_z = (res == 8'h00);
                end
                4'h7: begin nd = m_r[a]; m_r[a] = m_r[b]; end
                4'h8: begin nd = m_m[f[8:4]]; m_r[a] = nd; end
                4'h9: begin nd = m_m[f[12:8]]; m_m[f[12:8]] = m_r[f[7:4]]; end
                4'hA: begin nd = m_f[f[8:2]]; m_r[a] = nd; end
                4'hB: begin nd = m_f[f[12:6]]; m_f[f[12:6]] = m_r[f[5:2]]; end
                4'hC: begin nd = m_pc; npc = f[12:5]; end
                4'hD: begin nd = m_pc; if (!m_z) npc = f[12:5]; end
                4'hE: begin nd = m_pc; if (m_z) npc = f[12:5]; end
                default: nd = 8'h00;
            endcase
            m_pc = npc;
            e.dout = nd; e.pc = npc; e.op = op;
        end
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic r, input logic [16:0] f);
        @(negedge sysclk);
        reset = r;
        frame = f;
        model_step(r, f);
    endtask

    // monitor: every result is presented one cycle after its frame
    initial begin
        exp_t e;
        logic [3:0] leds;
        forever begin
            @(posedge sysclk);
            #1;
            cycle++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                leds = {LED, LED_R, LED_G, LED_B};
                checks++;
                if (dout !== e.dout) begin
                    failures++;
                    $display("FAIL dout cyc=%0d got=%h exp=%h", cycle, dout, e.dout);
                end
                checks++;
                if (pc !== e.pc) begin
                    failures++;
                    $display("FAIL pc cyc=%0d got=%h exp=%h", cycle, pc, e.pc);
                end
                checks++;
                if (leds !== ~e.op) begin
                    failures++;
                    $display("FAIL leds cyc=%0d got=%b exp=%b", cycle, leds, ~e.op);
                end
            end
        end
    end

    // driver
    initial begin
        reset = 1'b0;
        frame = '0;
        // reset with an ADD presented: must not execute
        issue(1'b0, mkf(4'h3, 4'h1, 4'h2, 4'h3));
        issue(1'b0, mkf(4'h3, 4'h1, 4'h2, 4'h3));
        // registers read back zero after reset
        for (int i = 0; i < 16; i++) issue(1'b1, mkf(4'h1, 4'(i), 4'h0, 4'h0));
        issue(1'b1, mkf(4'h2, 4'h1, 4'h5, 4'h0));
        issue(1'b1, mkf(4'h2, 4'h2, 4'h3, 4'h0));
        issue(1'b1, mkf(4'h3, 4'h1, 4'h2, 4'h3));
        issue(1'b1, mkf(4'h1, 4'h3, 4'h0, 4'h0));
        issue(1'b1, mkf(4'h4, 4'h1, 4'h1, 4'h4));
        issue(1'b1, mkf(4'h5, 4'h1, 4'h2, 4'h6));
        issue(1'b1, mkf(4'h1, 4'h6, 4'h0, 4'h0));
        issue(1'b1, mkf(4'h6, 4'h1, 4'h2, 4'h7));
        issue(1'b1, mkf(4'h1, 4'h7, 4'h0, 4'h0));
        issue(1'b1, mkf(4'h4, 4'h2, 4'h1, 4'h8));
        issue(1'b1, mkf(4'h1, 4'h8, 4'h0, 4'h0));
        issue(1'b1, mkf(4'h3, 4'h3, 4'h3, 4'h3));
        issue(1'b1, mkf(4'h1, 4'h3, 4'h0, 4'h0));
        issue(1'b1, mkf(4'h7, 4'h3, 4'h1, 4'h0));
        issue(1'b1, mkf(4'h1, 4'h3, 4'h0, 4'h0));
        issue(1'b1, mkf(4'h3, 4'h1, 4'h2, 4'h3));
        // SRAM at top address via R3
        issue(1'b1, {4'h9, 5'h1F, 4'h3, 4'h0});
        issue(1'b1, {4'h8, 4'h5, 5'h1F, 4'h0});
        issue(1'b1, mkf(4'h1, 4'h5, 4'h0, 4'h0));
        // flash at top address via R3
        issue(1'b1, {4'hB, 7'h7F, 4'h3, 2'b00});
        issue(1'b1, {4'hA, 4'h9, 7'h7F, 2'b00});
        issue(1'b1, mkf(4'h1, 4'h9, 4'h0, 4'h0));
        // jumps with Z set
        issue(1'b1, mkf(4'h4, 4'h1, 4'h1, 4'h4));
        issue(1'b1, {4'hE, 8'h40, 5'h00});
        issue(1'b1, {4'hD, 8'h20, 5'h00});
        issue(1'b1, {4'hC, 8'h10, 5'h00});
        // jumps with Z clear
        issue(1'b1, mkf(4'h6, 4'h1, 4'h2, 4'h7));
        issue(1'b1, {4'hE, 8'h40, 5'h00});
        issue(1'b1, {4'hD, 8'h20, 5'h00});
        // LED patterns and invalid opcode
        issue(1'b1, {4'hA, 13'h0000});
        issue(1'b1, {4'hF, 13'h1FFF});
        issue(1'b1, 17'h00000);
        // pc wraps through 0xFF
        for (int i = 0; i < 260; i++) issue(1'b1, 17'h00000);
        // randomized frames with occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [16:0] f;
            r = ($urandom_range(0, 99) != 0);
            f = 17'($urandom_range(0, 17'h1FFFF));
            issue(r, f);
        end
        issue(1'b1, 17'h00000);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge sysclk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_cpu_core.md
Name: frame_cpu_core

Overview:
- 8-bit single-cycle CPU core that executes one 17-bit instruction frame per sysclk cycle.
- Holds a 16x8 register file, 32x8 SRAM and 128x8 flash array; returns an 8-bit data word per cycle.
- Displays the current 4-bit opcode on four active-low LED outputs.
- The chip top wraps this block with the internal HF oscillator (sysclk source) and open-drain LED pad drivers.

Parameters:
- none (all widths and depths fixed as stated below)

Ports:
- sysclk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- frame  input  17  instruction frame: op=[16:13], fields below
- dout  output  8  registered data result
- pc  output  8  registered program counter
- LED_B  output  1  ~op_q[0]
- LED_G  output  1  ~op_q[1]
- LED_R  output  1  ~op_q[2]
- LED  output  1  ~op_q[3]

Behaviour:
- Reset (reset=0 at a rising edge) sets all regfile, SRAM and flash entries to 0x00, pc=0x00, dout=0x00, op_q=0x0, Z=0. LED_B/LED_G/LED_R/LED then all read 1 (off).
- Reset has priority over any frame presented in the same cycle. No instruction executes during reset.
- Out of reset, every cycle:
  - op_q <= frame[16:13].
  - pc <= pc+1, wrapping 0xFF -> 0x00, unless a taken jump overrides it.
- Field names: A=frame[12:9], B=frame[8:5], D=frame[4:1].
- All reads use pre-edge state. dout reports the OLD value of the addressed location (read-before-write).
- Opcodes:
  - 0x0 NOP: dout=0x00.
  - 0x1 LOAD: dout=R[A].
  - 0x2 STORE: R[A]<= {4'b0,B}; dout=old R[A].
  - 0x3 ADD: R[D]<=R[A]+R[B] mod 256; dout=old R[D]; Z<=(result==0).
  - 0x4 SUB: R[D]<=R[A]-R[B] mod 256; dout=old R[D]; Z<=(result==0).
  - 0x5 AND: R[D]<=R[A]&R[B]; dout=old R[D]; Z updated.
  - 0x6 OR: R[D]<=R[A]|R[B]; dout=old R[D]; Z updated.
  - 0x7 MOV: R[A]<=R[B]; dout=old R[A].
  - 0x8 SRAM LOAD: R[A]<=M[frame[8:4]]; dout=M[frame[8:4]].
  - 0x9 SRAM STORE: M[frame[12:8]]<=R[frame[7:4]]; dout=old M[frame[12:8]].
  - 0xA FLASH LOAD: R[A]<=F[frame[8:2]]; dout=F[frame[8:2]].
  - 0xB FLASH STORE: F[frame[12:6]]<=R[frame[5:2]]; dout=old F[frame[12:6]].
  - 0xC JMP: pc<=frame[12:5]; dout=old pc.
  - 0xD JNE: if Z==0 pc<=frame[12:5], else pc<=pc+1; dout=old pc.
  - 0xE JEQ: if Z==1 pc<=frame[12:5], else pc<=pc+1; dout=old pc.
  - 0xF invalid: dout=0x00; no state change except pc+1 and op_q.
- Z changes only on opcodes 0x3-0x6.
- When a source and the destination are the same register (e.g. ADD with D==A), the source value is the pre-edge value.
- The frame is not registered: it must be stable around each rising edge. Latency is 1 cycle from frame to dout/pc/LED.
- LED outputs are pure inversions of op_q (combinational from the register). Low = LED lit.

Test Plan:
- Hold reset=0 for 2 cycles with frame op=0x3 -> dout=0x00, pc=0x00, all LEDs=1, R[*]=0. Release -> pc counts 1,2,3..., wraps 0xFF->0x00.
- STORE R1=0x5, STORE R2=0x3, ADD D=3, then LOAD A=3:
  - ADD cycle dout=0x00 (old R3).
  - LOAD returns 0x08.
  - SUB R1-R1 into R4 -> Z=1.
- AND R1(0x05)&R2(0x03) -> 0x01; OR -> 0x07; SUB R2-R1 -> 0xFE (wrap). Z=0 after each.
- SRAM STORE addr 0x1F from R3 (0x08), then SRAM LOAD into R5 -> dout=0x08, R5=0x08. Same check for FLASH STORE/LOAD at addr 0x7F.
- With Z=1: JEQ target 0x40 -> pc=0x40 and dout=old pc; JNE 0x20 -> pc=0x41. JMP 0x10 -> pc=0x10.
- op=0xA -> LED=0, LED_R=1, LED_G=0, LED_B=1 next cycle. op=0xF -> dout=0x00, all LEDs=0.
